mem_access_ctrl: RTL

Memory-stage controller for the 16-bit RISC pipeline. Accepts one decoded memory operation at a time (LDM, LDD, STD, PUSH, POP, CALL, RET), owns the stack pointer, sequences one or two single-port data-memory accesses through a req/ack handshake, and stalls the pipeline until each operation completes. Sits between the execute-stage memory-instruction units and the data memory. Returns the loaded value plus the carried-through condition flags to write-back.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_access_ctrl_sp_unit.sv | 65 ++++++
 rtl/mem_access_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: op encodings, FSM states
// and the condition-code width.
package mem_ctrl_pkg;

    localparam int CCR_W = 3;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDM  = 3'd1;
    localparam logic [2:0] OP_LDD  = 3'd2;
    localparam logic [2:0] OP_STD  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_POP  = 3'd5;
    localparam logic [2:0] OP_CALL = 3'd6;
    localparam logic [2:0] OP_RET  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_sp_unit.sv
// Stack-pointer register with +/-1 update and neighbour-address generation.
// With STACK_CHECK_EN defined it also flags stack over/underflow for an offered op.
module sp_unit
    import mem_ctrl_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] SP_INIT  = 16'hFFFF,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 16'hF800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
`ifdef STACK_CHECK_EN
    input  logic [2:0]        op,
    output logic              chk_err,
`endif
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_m1,
    output logic [ADDR_W-1:0] sp_p1,
    output logic [ADDR_W-1:0] sp_p2
);

    logic [ADDR_W-1:0] sp_q, sp_d;

    always_comb begin
        sp_d = sp_q;
        if (inc) begin
            sp_d = sp_q + ADDR_W'(1);
        end else if (dec) begin
            sp_d = sp_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= SP_INIT;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp    = sp_q;
    assign sp_m1 = sp_q - ADDR_W'(1);
    assign sp_p1 = sp_q + ADDR_W'(1);
    assign sp_p2 = sp_q + ADDR_W'(2);

`ifdef STACK_CHECK_EN
    // One extra bit so SP+1 / SP+2 past the top and SP-1 below zero do not wrap.
    logic [ADDR_W:0] sp_w;
    assign sp_w = {1'b0, sp_q};

    always_comb begin
        chk_err = 1'b0;
        case (op)
            OP_PUSH: chk_err = (sp_q < SP_LIMIT);
            OP_CALL: chk_err = (sp_w < ({1'b0, SP_LIMIT} + (ADDR_W+1)'(1)));
            OP_POP:  chk_err = ((sp_w + (ADDR_W+1)'(1)) > {1'b0, SP_INIT});
            OP_RET:  chk_err = ((sp_w + (ADDR_W+1)'(2)) > {1'b0, SP_INIT});
            default: chk_err = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: sequences LDM/LDD/STD/PUSH/POP/CALL/RET through a
// req/ack data-memory port. Optional stack bounds checking via STACK_CHECK_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] SP_INIT  = 16'hFFFF,
    parameter logic [ADDR_W-1:0] SP_LIMIT = 16'hF800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [2:0]          op,
    output logic                op_ready,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [2*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]   imm,
    input  logic [CCR_W-1:0]    flags_in,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                res_valid,
    output logic [2*DATA_W-1:0] res_data,
    output logic [CCR_W-1:0]    res_flags,
    output logic [ADDR_W-1:0]   sp,
    output logic                stack_err
);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   wlo_q, wlo_d;
    logic [DATA_W-1:0]   rlo_q, rlo_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                res_valid_q, res_valid_d;
    logic [2*DATA_W-1:0] res_data_q, res_data_d;
    logic [CCR_W-1:0]    res_flags_q, res_flags_d;
    logic                stack_err_q, stack_err_d;

    logic                sp_inc, sp_dec, chk_err, acked;
    logic [ADDR_W-1:0]   sp_cur, sp_m1, sp_p1, sp_p2;

    sp_unit #(
        .ADDR_W   (ADDR_W),
        .SP_INIT  (SP_INIT),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp (
        .clk     (clk),
        .rst     (rst),
        .inc     (sp_inc),
        .dec     (sp_dec),
`ifdef STACK_CHECK_EN
        .op      (op),
        .chk_err (chk_err),
`endif
        .sp      (sp_cur),
        .sp_m1   (sp_m1),
        .sp_p1   (sp_p1),
        .sp_p2   (sp_p2)
    );

`ifndef STACK_CHECK_EN
    assign chk_err = 1'b0;
`endif

    assign acked = mem_req_q && mem_ack;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wlo_d       = wlo_q;
        rlo_d       = rlo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        stack_err_d = 1'b0;
        sp_inc      = 1'b0;
        sp_dec      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d        = op;
                    wlo_d       = wdata[DATA_W-1:0];
                    res_flags_d = flags_in;
                    if (chk_err) begin
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        stack_err_d = 1'b1;
                    end else begin
                        case (op)
                            OP_NOP: begin
                                res_valid_d = 1'b1;
                                res_data_d  = '0;
                            end
                            OP_LDM: begin
                                res_valid_d = 1'b1;
                                res_data_d  = {{DATA_W{1'b0}}, imm};
                            end
                            default: begin
                                state_d   = S_ACC1;
                                mem_req_d = 1'b1;
                                // Writes go to SP (or addr_in); stack reads come from SP+1.
                                mem_we_d  = (op == OP_STD) || (op == OP_PUSH) || (op == OP_CALL);
                                mem_wdata_d = (op == OP_CALL) ? wdata[2*DATA_W-1:DATA_W]
                                                              : wdata[DATA_W-1:0];
                                if (op == OP_LDD || op == OP_STD) begin
                                    mem_addr_d = addr_in;
                                end else if (op == OP_POP || op == OP_RET) begin
                                    mem_addr_d = sp_p1;
                                end else begin
                                    mem_addr_d = sp_cur;
                                end
                            end
                        endcase
                    end
                end
            end

            S_ACC1: begin
                if (acked) begin
                    mem_req_d = 1'b0;
                    sp_dec    = (op_q == OP_PUSH) || (op_q == OP_CALL);
                    sp_inc    = (op_q == OP_POP)  || (op_q == OP_RET);
                    // Second access address uses the pre-update SP, since SP moves on this same edge.
                    if (op_q == OP_CALL) begin
                        state_d     = S_ACC2;
                        mem_addr_d  = sp_m1;
                        mem_wdata_d = wlo_q;
                    end else if (op_q == OP_RET) begin
                        state_d    = S_ACC2;
                        rlo_d      = mem_rdata;
                        mem_addr_d = sp_p2;
                    end else begin
                        state_d     = S_IDLE;
                        res_valid_d = 1'b1;
                        res_data_d  = mem_we_q ? '0 : {{DATA_W{1'b0}}, mem_rdata};
                    end
                end
            end

            S_ACC2: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (acked) begin
                    mem_req_d   = 1'b0;
                    state_d     = S_IDLE;
                    res_valid_d = 1'b1;
                    res_data_d  = mem_we_q ? '0 : {mem_rdata, rlo_q};
                    sp_dec      = (op_q == OP_CALL);
                    sp_inc      = (op_q == OP_RET);
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            wlo_q       <= '0;
            rlo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wlo_q       <= wlo_d;
            rlo_q       <= rlo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;
    assign sp        = sp_cur;
    assign stack_err = stack_err_q;

endmodule
